// File: rtl/multibyte_add_sequencer.sv
// -----------------------------------------------------------------------------
// multibyte_add_sequencer
//
// Purpose:
//   Performs a W-bit addition (W = 8*NBYTES) over several cycles using a single
//   8-bit ripple-carry adder slice. Operands are accepted from a valid/ready
//   producer, the slice is fed one byte pair per cycle starting at the least
//   significant byte, and the slice carry-out is chained into the next byte's
//   carry-in. The finished sum, the carry out of the top byte and the signed
//   overflow flag are then offered to a valid/ready consumer.
//
// Ports:
//   clk        system clock, all state changes on the rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   operand request valid
//   in_ready   operands can be accepted (high only while idle)
//   in_a       operand A (W bits)
//   in_b       operand B (W bits)
//   in_cin     carry into byte 0
//   out_valid  result valid (high only while the result is pending)
//   out_ready  consumer accepts the result
//   out_sum    W-bit sum, modulo 2^W
//   out_cout   carry out of the most significant byte
//   out_ovf    two's-complement overflow of the addition
//   busy       high while an operation is running or its result is pending
//
// Handshake semantics (both ports): a transfer happens on a rising edge where
// valid and ready are both high. Ready and valid are decoded purely from the
// state register, so neither depends combinationally on the partner's signal.
// -----------------------------------------------------------------------------

// -----------------------------------------------------------------------------
// ripple_carry_adder8
//
// Purpose:
//   8-bit ripple-carry adder slice built from a chain of full adders.
//
// Ports:
//   a, b   8-bit addends
//   cin    carry into bit 0
//   sum    8-bit sum
//   cout   carry out of bit 7
// -----------------------------------------------------------------------------
module ripple_carry_adder8 (
   input  logic [7:0] a,
   input  logic [7:0] b,
   input  logic       cin,
   output logic [7:0] sum,
   output logic       cout
);

   logic [8:0] carry_chain;

   assign carry_chain[0] = cin;

   for (genvar i = 0; i < 8; i++) begin : g_bit
      logic half_sum;
      assign half_sum           = a[i] ^ b[i];
      assign sum[i]             = half_sum ^ carry_chain[i];
      // Generate when both bits are set, propagate the incoming carry otherwise.
      assign carry_chain[i + 1] = (a[i] & b[i]) | (carry_chain[i] & half_sum);
   end

   assign cout = carry_chain[8];

endmodule

module multibyte_add_sequencer #(
   parameter int NBYTES = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [8*NBYTES-1:0] in_a,
   input  logic [8*NBYTES-1:0] in_b,
   input  logic                in_cin,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [8*NBYTES-1:0] out_sum,
   output logic                out_cout,
   output logic                out_ovf,
   output logic                busy
);

   localparam int W  = 8 * NBYTES;
   // Byte index width; at least one bit so the declaration stays legal.
   localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // The state register is kept as a plainly named signal so checkers can
   // bind to it directly.
   state_t        state;
   logic [IW-1:0] idx;
   logic          carry;
   logic [W-1:0]  a_reg;
   logic [W-1:0]  b_reg;
   logic [W-1:0]  sum_reg;

   logic [7:0]    slice_a;
   logic [7:0]    slice_b;
   logic [7:0]    slice_sum;
   logic          slice_cout;
   logic [W-1:0]  sum_next;
   logic          ovf_next;

   // Byte select: {idx, 3'b000} is 8*idx without a width-changing multiply.
   assign slice_a = a_reg[{idx, 3'b000} +: 8];
   assign slice_b = b_reg[{idx, 3'b000} +: 8];

   ripple_carry_adder8 u_slice (
      .a    (slice_a),
      .b    (slice_b),
      .cin  (carry),
      .sum  (slice_sum),
      .cout (slice_cout)
   );

   // Sum register with the byte currently being computed merged in. On the
   // last step this is the complete result, so it can be published directly.
   always_comb begin
      sum_next                       = sum_reg;
      sum_next[{idx, 3'b000} +: 8]   = slice_sum;
   end

   // Only meaningful on the last step, when the slice is producing the top
   // byte and slice_sum[7] is the sign bit of the result.
   assign ovf_next = (a_reg[W-1] == b_reg[W-1]) && (slice_sum[7] != a_reg[W-1]);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         idx      <= '0;
         carry    <= 1'b0;
         a_reg    <= '0;
         b_reg    <= '0;
         sum_reg  <= '0;
         out_sum  <= '0;
         out_cout <= 1'b0;
         out_ovf  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_reg   <= in_a;
                  b_reg   <= in_b;
                  carry   <= in_cin;
                  idx     <= '0;
                  sum_reg <= '0;
                  state   <= RUN;
               end
            end

            RUN: begin
               sum_reg <= sum_next;
               carry   <= slice_cout;
               if (idx == LAST_IDX) begin
                  // Outputs only change here, so they hold their value through
                  // DONE and after the output handshake until the next result.
                  out_sum  <= sum_next;
                  out_cout <= slice_cout;
                  out_ovf  <= ovf_next;
                  idx      <= '0;
                  state    <= DONE;
               end else begin
                  idx <= idx + 1'b1;
               end
            end

            DONE: begin
               if (out_ready) begin
                  state <= IDLE;
               end
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // Decoded from the state register only: no path from in_valid or out_ready.
   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign busy      = (state != IDLE);

endmodule

// File: tb/tb_multibyte_add_sequencer.sv
// -----------------------------------------------------------------------------
// tb_multibyte_add_sequencer
//
// Bench for multibyte_add_sequencer with NBYTES = 4. A behavioural model
// tracks the expected handshake timing as a cycle count and the expected result
// as a (W+1)-bit integer sum; a compare process checks the DUT against it on
// every falling edge. Directed sequences add literal expectations on top.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_multibyte_add_sequencer;

   localparam int NBYTES = 4;
   localparam int W      = 8 * NBYTES;

   // ---------------------------------------------------------------- clock/reset
   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] in_a = '0;
   logic [W-1:0] in_b = '0;
   logic         in_cin = 1'b0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] out_sum;
   logic         out_cout;
   logic         out_ovf;
   logic         busy;

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   multibyte_add_sequencer #(.NBYTES(NBYTES)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_cin    (in_cin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_cout  (out_cout),
      .out_ovf   (out_ovf),
      .busy      (busy)
   );

   // ---------------------------------------------------------------- checking
   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------- model
   // Phase: 0 = waiting for operands, 1 = counting down the byte steps,
   // 2 = result pending. Expected results come from plain wide arithmetic.
   int           m_phase = 0;
   int           m_left  = 0;
   int           ops_done = 0;
   logic [W:0]   m_full;
   logic [W-1:0] m_pend_sum = '0;
   logic         m_pend_cout = 1'b0;
   logic         m_pend_ovf = 1'b0;
   logic [W-1:0] m_sum = '0;
   logic         m_cout = 1'b0;
   logic         m_ovf = 1'b0;
   logic [W-1:0] exp_q[$];

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_phase = 0;
         m_left  = 0;
         m_sum   = '0;
         m_cout  = 1'b0;
         m_ovf   = 1'b0;
         exp_q.delete();
      end else begin
         case (m_phase)
            0: if (in_valid) begin
               m_full      = {1'b0, in_a} + {1'b0, in_b} + {{W{1'b0}}, in_cin};
               m_pend_sum  = m_full[W-1:0];
               m_pend_cout = m_full[W];
               m_pend_ovf  = (in_a[W-1] == in_b[W-1]) && (m_full[W-1] != in_a[W-1]);
               exp_q.push_back(m_pend_sum);
               m_left      = NBYTES;
               m_phase     = 1;
            end
            1: begin
               m_left--;
               if (m_left == 0) begin
                  m_sum   = exp_q.pop_front();
                  m_cout  = m_pend_cout;
                  m_ovf   = m_pend_ovf;
                  m_phase = 2;
               end
            end
            default: if (out_ready) begin
               m_phase = 0;
               ops_done++;
            end
         endcase
      end
   end

   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         check("in_ready",  64'(in_ready),  64'(m_phase == 0));
         check("out_valid", 64'(out_valid), 64'(m_phase == 2));
         check("busy",      64'(busy),      64'(m_phase != 0));
         check("out_sum",   64'(out_sum),   64'(m_sum));
         check("out_cout",  64'(out_cout),  64'(m_cout));
         check("out_ovf",   64'(out_ovf),   64'(m_ovf));
      end
   end

   // ---------------------------------------------------------------- drivers
   function automatic logic [W-1:0] rand_op();
      logic [W-1:0] r;
      case ($urandom_range(0, 7))
         0: r = '1;
         1: r = {1'b0, {(W-1){1'b1}}};
         2: r = {1'b1, {(W-1){1'b0}}};
         3: r = '0;
         default: for (int i = 0; i < NBYTES; i++) r[8*i +: 8] = 8'($urandom_range(0, 255));
      endcase
      return r;
   endfunction

   // Called at posedge+#1; returns once in_ready is high (next edge accepts).
   task automatic wait_ready(input string name);
      int n;
      n = 0;
      while (!in_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      if (!in_ready) check({name, "_ready_timeout"}, 64'(n), 64'd0);
   endtask

   task automatic wait_valid(input string name, output int lat);
      lat = 0;
      while (!out_valid && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      if (!out_valid) check({name, "_valid_timeout"}, 64'(lat), 64'd0);
   endtask

   task automatic directed(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic cin, input logic [W-1:0] es, input logic ec, input logic eo);
      int lat;
      in_valid = 1'b1; in_a = a; in_b = b; in_cin = cin; out_ready = 1'b0;
      wait_ready(name);
      @(posedge clk); #1;
      // Operands change after acceptance; the result must not follow them.
      in_valid = 1'b0; in_a = rand_op(); in_b = rand_op(); in_cin = ~cin;
      wait_valid(name, lat);
      check({name, "_latency"}, 64'(lat), 64'(NBYTES));
      check({name, "_sum"},  64'(out_sum),  64'(es));
      check({name, "_cout"}, 64'(out_cout), 64'(ec));
      check({name, "_ovf"},  64'(out_ovf),  64'(eo));
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check({name, "_idle_after"}, 64'(in_ready), 64'd1);
   endtask

   // ---------------------------------------------------------------- sequence
   initial begin
      int lat;
      int first;
      int second;
      int start;
      int k;

      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_in_ready",  64'(in_ready),  64'd1);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_busy",      64'(busy),      64'd0);
      check("rst_out_sum",   64'(out_sum),   64'd0);
      check("rst_out_cout",  64'(out_cout),  64'd0);
      check("rst_out_ovf",   64'(out_ovf),   64'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      directed("carry_byte1", 32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 1'b0, 1'b0);
      directed("ripple_all",  32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 1'b1, 1'b0);
      directed("pos_ovf",     32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1);
      directed("neg_ovf",     32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1);

      // Backpressure: result held while new operands are offered.
      in_valid = 1'b1; in_a = 32'h00000010; in_b = 32'h00000020; in_cin = 1'b0; out_ready = 1'b0;
      wait_ready("bp");
      @(posedge clk); #1;
      in_valid = 1'b0;
      wait_valid("bp", lat);
      in_valid = 1'b1; in_a = 32'h01010101; in_b = 32'h02020202; in_cin = 1'b1;
      repeat (5) begin
         @(posedge clk); #1;
         check("bp_out_valid", 64'(out_valid), 64'd1);
         check("bp_in_ready",  64'(in_ready),  64'd0);
         check("bp_out_sum",   64'(out_sum),   64'h30);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check("bp_release_idle",  64'(in_ready),  64'd1);
      check("bp_release_valid", 64'(out_valid), 64'd0);
      check("bp_sum_held",      64'(out_sum),   64'h30);
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("bp_second_accept", 64'(busy), 64'd1);
      wait_valid("bp2", lat);
      check("bp2_sum",  64'(out_sum),  64'h03030304);
      check("bp2_cout", 64'(out_cout), 64'd0);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;

      // Reset after two byte steps discards the operation.
      in_valid = 1'b1; in_a = 32'hAAAAAAAA; in_b = 32'h55555555; in_cin = 1'b1;
      wait_ready("mid_rst");
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk);
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      check("mid_rst_out_valid", 64'(out_valid), 64'd0);
      check("mid_rst_out_sum",   64'(out_sum),   64'd0);
      check("mid_rst_busy",      64'(busy),      64'd0);
      check("mid_rst_in_ready",  64'(in_ready),  64'd1);
      @(posedge clk); #1;
      rst_n = 1'b1;
      directed("after_rst", 32'h12345678, 32'h11111111, 1'b0, 32'h23456789, 1'b0, 1'b0);

      // Back-to-back with both valids held high.
      in_valid = 1'b1; out_ready = 1'b1; in_a = 32'h00010000; in_b = 32'h0000FFFF; in_cin = 1'b1;
      first = -1; second = -1;
      for (int i = 0; i < 40; i++) begin
         if (in_ready) begin
            if (first < 0) first = cyc + 1;
            else second = cyc + 1;
         end
         if (second >= 0) break;
         @(posedge clk); #1;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("b2b_accept_spacing", 64'(second - first), 64'(NBYTES + 2));
      k = 0;
      while (busy && k < 40) begin
         @(posedge clk); #1;
         k++;
      end
      out_ready = 1'b0;

      // Randomized traffic, checked every cycle by the model.
      start = ops_done;
      k = 0;
      while (ops_done < start + 1000 && k < 30000) begin
         in_valid  = 1'($urandom_range(0, 1));
         in_a      = rand_op();
         in_b      = rand_op();
         in_cin    = 1'($urandom_range(0, 1));
         out_ready = ($urandom_range(0, 3) != 0);
         @(posedge clk); #1;
         k++;
      end
      check("random_ops_completed", 64'(ops_done - start >= 1000), 64'd1);
      in_valid = 1'b0; out_ready = 1'b1;
      repeat (NBYTES + 4) begin
         @(posedge clk); #1;
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1, "watchdog");
   end

endmodule
